// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- four-way round-robin arbiter in front of a single uart_tx.
//
// Each requester raises its req bit with a byte on its req_data lane. The
// arbiter picks one winner per transfer, hands the byte and baud select to
// the transmitter with a one-cycle tx_send_en pulse, then waits for tx_done
// before reporting completion on done[owner] and going back to arbitrate.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   req[3:0]     per-requester send request, held until granted
//   req_data     byte of requester k on bits [8k+7:8k]
//   bps_cfg      baud select, captured at grant time
//   tx_done      end-of-frame pulse from uart_tx
//   grant        one-hot pulse in the LOAD cycle
//   done         one-hot pulse after the owner's frame completes
//   tx_send_en   start pulse to uart_tx
//   tx_data      byte to uart_tx, held from LOAD until the next grant
//   tx_bps_set   baud select to uart_tx, held for the whole transfer
//   busy         high while in LOAD or WAIT
//   timeout_err  pulse when WAIT gives up waiting for tx_done
//
// Optional build macro UART_ARB_TIMEOUT_EN: when defined, WAIT is bounded by
// TIMEOUT_CYCLES cycles; otherwise WAIT lasts until tx_done and timeout_err
// is constant 0.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer; arbitrate among req each cycle
// LOAD   | grant/tx_send_en pulse to the winner, byte handed to uart_tx
// WAIT   | frame in flight; wait for tx_done (or timeout when enabled)

module uart_tx_arb #(
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd600000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  input  logic [2:0]  bps_cfg,
  input  logic        tx_done,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic        tx_send_en,
  output logic [7:0]  tx_data,
  output logic [2:0]  tx_bps_set,
  output logic        busy,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  owner, owner_nxt;
  logic [1:0]  last_owner, last_owner_nxt;
  logic [3:0]  grant_nxt, done_nxt;
  logic        send_nxt, busy_nxt, timeout_nxt;
  logic [7:0]  tx_data_nxt;
  logic [2:0]  bps_nxt;

  logic [1:0]  winner, cand;
  logic        win_found;
  logic        wait_limit;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    winner    = 2'd0;
    win_found = 1'b0;
    cand      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = last_owner + 2'(i + 1);
      if (!win_found && req[cand]) begin
        winner    = cand;
        win_found = 1'b1;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [19:0] wait_cnt;

  // wait_cnt counts completed WAIT cycles, so the limit hits on the
  // TIMEOUT_CYCLES-th WAIT cycle.
  assign wait_limit = (20'(wait_cnt + 20'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 20'd0;
    end else if (state == S_LOAD) begin
      wait_cnt <= 20'd0;
    end else if (state == S_WAIT) begin
      wait_cnt <= 20'(wait_cnt + 20'd1);
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign wait_limit            = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    tx_data_nxt    = tx_data;
    bps_nxt        = tx_bps_set;
    grant_nxt      = 4'b0000;
    done_nxt       = 4'b0000;
    send_nxt       = 1'b0;
    timeout_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          state_nxt   = S_LOAD;
          owner_nxt   = winner;
          tx_data_nxt = req_data[{winner, 3'b000} +: 8];
          bps_nxt     = bps_cfg;
          grant_nxt   = 4'b0001 << winner;
          send_nxt    = 1'b1;
        end
      end
      S_LOAD: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // tx_done wins over a timeout landing in the same cycle.
        if (tx_done) begin
          done_nxt       = 4'b0001 << owner;
          last_owner_nxt = owner;
          state_nxt      = S_IDLE;
        end else if (wait_limit) begin
          timeout_nxt    = 1'b1;
          last_owner_nxt = owner;
          state_nxt      = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      owner       <= 2'd0;
      last_owner  <= 2'd3;
      grant       <= 4'b0000;
      done        <= 4'b0000;
      tx_send_en  <= 1'b0;
      tx_data     <= 8'd0;
      tx_bps_set  <= 3'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_owner  <= last_owner_nxt;
      grant       <= grant_nxt;
      done        <= done_nxt;
      tx_send_en  <= send_nxt;
      tx_data     <= tx_data_nxt;
      tx_bps_set  <= bps_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed testbench for uart_tx_arb. Outputs are sampled 1 ns after each
// rising edge; inputs are changed at the same point for the next edge.

module tb_uart_tx_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [2:0]  bps_cfg;
  logic        tx_done;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        tx_send_en;
  logic [7:0]  tx_data;
  logic [2:0]  tx_bps_set;
  logic        busy;
  logic        timeout_err;

  int checks   = 0;
  int failures = 0;

  uart_tx_arb #(.TIMEOUT_CYCLES(20'd16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .bps_cfg     (bps_cfg),
    .tx_done     (tx_done),
    .grant       (grant),
    .done        (done),
    .tx_send_en  (tx_send_en),
    .tx_data     (tx_data),
    .tx_bps_set  (tx_bps_set),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".grant"}, 32'(grant), 32'h0);
    chk({tag, ".done"}, 32'(done), 32'h0);
    chk({tag, ".send"}, 32'(tx_send_en), 32'h0);
    chk({tag, ".data"}, 32'(tx_data), 32'h0);
    chk({tag, ".bps"}, 32'(tx_bps_set), 32'h0);
    chk({tag, ".busy"}, 32'(busy), 32'h0);
    chk({tag, ".tmo"}, 32'(timeout_err), 32'h0);
  endtask

  logic [1:0] exp_order [5];
  logic [7:0] exp_byte  [5];

  initial begin
    exp_order[0] = 2'd0; exp_order[1] = 2'd1; exp_order[2] = 2'd2;
    exp_order[3] = 2'd3; exp_order[4] = 2'd0;
    exp_byte[0]  = 8'h11; exp_byte[1] = 8'h22; exp_byte[2] = 8'h33;
    exp_byte[3]  = 8'h44; exp_byte[4] = 8'h11;

    rst = 1'b1; req = 4'h0; req_data = 32'h0; bps_cfg = 3'd0; tx_done = 1'b0;
    tick();
    tick();
    chk_idle_outputs("reset");

    // Single request from requester 0.
    rst = 1'b0; req = 4'b0001; req_data = 32'h000000A5; bps_cfg = 3'd2;
    tick();
    chk("r19.grant", 32'(grant), 32'h1);
    chk("r19.send", 32'(tx_send_en), 32'h1);
    chk("r19.data", 32'(tx_data), 32'hA5);
    chk("r19.bps", 32'(tx_bps_set), 32'h2);
    chk("r19.busy_load", 32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("r19.grant_off", 32'(grant), 32'h0);
    chk("r19.send_off", 32'(tx_send_en), 32'h0);
    chk("r19.busy_wait", 32'(busy), 32'h1);
    tick();
    chk("r19.no_done", 32'(done), 32'h0);
    tx_done = 1'b1;
    tick();
    chk("r19.done", 32'(done), 32'h1);
    chk("r19.busy_idle", 32'(busy), 32'h0);
    chk("r19.data_hold", 32'(tx_data), 32'hA5);

    // Stray tx_done in IDLE, then in LOAD.
    tick();
    chk("r24.idle_done", 32'(done), 32'h0);
    chk("r24.idle_busy", 32'(busy), 32'h0);
    tx_done = 1'b0; req = 4'b0010; req_data = 32'h00005A00;
    tick();
    chk("r24.grant", 32'(grant), 32'h2);
    chk("r24.data", 32'(tx_data), 32'h5A);
    req = 4'b0000; tx_done = 1'b1;
    tick();
    chk("r24.load_done", 32'(done), 32'h0);
    chk("r24.load_busy", 32'(busy), 32'h1);
    tx_done = 1'b0;
    tick();
    chk("r24.still_wait", 32'(busy), 32'h1);
    tx_done = 1'b1;
    tick();
    chk("r24.done", 32'(done), 32'h2);
    tx_done = 1'b0;

    // Rotation with all four requesting, starting fresh from reset.
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b1111; req_data = 32'h44332211; bps_cfg = 3'd1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk($sformatf("r20.grant%0d", n), 32'(grant), 32'(4'b0001 << exp_order[n]));
      chk($sformatf("r20.data%0d", n), 32'(tx_data), 32'(exp_byte[n]));
      tick();
      tx_done = 1'b1;
      tick();
      chk($sformatf("r20.done%0d", n), 32'(done), 32'(4'b0001 << exp_order[n]));
      tx_done = 1'b0;
    end
    req = 4'b0000;

    // Input changes during LOAD/WAIT must not disturb the transfer.
    tick();
    req = 4'b1000; req_data = 32'h77000000; bps_cfg = 3'd2;
    tick();
    chk("r21.grant", 32'(grant), 32'h8);
    chk("r21.data", 32'(tx_data), 32'h77);
    req = 4'b1111; req_data = 32'hFFFFFFFF; bps_cfg = 3'd5;
    tick();
    chk("r21.data_w1", 32'(tx_data), 32'h77);
    chk("r21.bps_w1", 32'(tx_bps_set), 32'h2);
    tick();
    chk("r21.data_w2", 32'(tx_data), 32'h77);
    chk("r21.bps_w2", 32'(tx_bps_set), 32'h2);
    tx_done = 1'b1;
    tick();
    chk("r21.done", 32'(done), 32'h8);
    chk("r21.data_done", 32'(tx_data), 32'h77);
    tx_done = 1'b0;
    tick();
    chk("r21.next_grant", 32'(grant), 32'h1);
    chk("r21.next_data", 32'(tx_data), 32'hFF);
    chk("r21.next_bps", 32'(tx_bps_set), 32'h5);
    req = 4'b0000;
    tick();

    // Reset in WAIT aborts with no done pulse.
    rst = 1'b1; req_data = 32'hC3B2A190;
    tick();
    chk_idle_outputs("r22.rst");
    rst = 1'b0; req = 4'b0100;
    tick();
    chk("r22.grant", 32'(grant), 32'h4);
    chk("r22.data", 32'(tx_data), 32'hB2);
    req = 4'b0000;

`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("r23.wait%0d_tmo", i), 32'(timeout_err), 32'h0);
      chk($sformatf("r23.wait%0d_busy", i), 32'(busy), 32'h1);
    end
    tick();
    chk("r23.tmo", 32'(timeout_err), 32'h1);
    chk("r23.no_done", 32'(done), 32'h0);
    chk("r23.busy", 32'(busy), 32'h0);
    req = 4'b0001;
    tick();
    chk("r23.tmo_off", 32'(timeout_err), 32'h0);
    chk("r23.next_grant", 32'(grant), 32'h1);
    chk("r23.next_data", 32'(tx_data), 32'h90);
    req = 4'b0000;
    tick();
    tx_done = 1'b1;
    tick();
    chk("r23.next_done", 32'(done), 32'h1);
    tx_done = 1'b0;
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("r18.wait%0d_tmo", i), 32'(timeout_err), 32'h0);
      chk($sformatf("r18.wait%0d_busy", i), 32'(busy), 32'h1);
    end
    tx_done = 1'b1;
    tick();
    chk("r18.done", 32'(done), 32'h4);
    chk("r18.busy", 32'(busy), 32'h0);
    tx_done = 1'b0;
`endif
    tick();
    chk("end.done_off", 32'(done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
